// File: rtl/hpdcache_wbuf_dir_ctrl.sv
// Write-buffer directory controller: tracks cache-line entries FREE -> OPEN -> PEND -> SENT,
// coalesces writes into OPEN lines and hands closed lines to the memory send channel.
module hpdcache_wbuf_dir_ctrl #(
    parameter int unsigned DIR_ENTRIES   = 8,
    parameter int unsigned TAG_WIDTH     = 43,
    parameter int unsigned TIMECNT_WIDTH = 5,
    parameter int unsigned ID_WIDTH      = $clog2(DIR_ENTRIES)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [TIMECNT_WIDTH-1:0] cfg_threshold_i,
    input  logic                     cfg_reset_timecnt_on_write_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [TAG_WIDTH-1:0]     wr_tag_i,
    output logic [ID_WIDTH-1:0]      wr_id_o,
    input  logic                     flush_all_i,
    output logic                     send_valid_o,
    input  logic                     send_ready_i,
    output logic [TAG_WIDTH-1:0]     send_tag_o,
    output logic [ID_WIDTH-1:0]      send_id_o,
    input  logic                     ack_valid_i,
    input  logic [ID_WIDTH-1:0]      ack_id_i,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam logic [1:0] ST_FREE = 2'd0;
    localparam logic [1:0] ST_OPEN = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;
    localparam logic [1:0] ST_SENT = 2'd3;

    logic [1:0]               state_q   [DIR_ENTRIES];
    logic [1:0]               state_d   [DIR_ENTRIES];
    logic [TAG_WIDTH-1:0]     tag_q     [DIR_ENTRIES];
    logic [TAG_WIDTH-1:0]     tag_d     [DIR_ENTRIES];
    logic [TIMECNT_WIDTH-1:0] timecnt_q [DIR_ENTRIES];
    logic [TIMECNT_WIDTH-1:0] timecnt_d [DIR_ENTRIES];

    logic                     lock_valid_q, lock_valid_d;
    logic [ID_WIDTH-1:0]      lock_id_q,    lock_id_d;
    logic [TAG_WIDTH-1:0]     lock_tag_q,   lock_tag_d;

    logic [DIR_ENTRIES-1:0]   hit_s, hazard_s, free_s, pend_s, close_s;
    logic                     hit_any_s, hazard_any_s, free_any_s, pend_any_s;
    logic [ID_WIDTH-1:0]      hit_id_s, free_id_s, pend_id_s;
    logic                     wr_alloc_s, send_hs_s, ack_sent_s;

    function automatic logic [ID_WIDTH-1:0] first_set(input logic [DIR_ENTRIES-1:0] vec);
        logic [ID_WIDTH-1:0] idx;
        idx = '0;
        for (int i = int'(DIR_ENTRIES) - 1; i >= 0; i--) begin
            idx = vec[i] ? ID_WIDTH'(i) : idx;
        end
        return idx;
    endfunction

    // Per-entry tag compare and state classification
    always_comb begin
        hit_s    = '0;
        hazard_s = '0;
        free_s   = '0;
        pend_s   = '0;
        close_s  = '0;
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            hit_s[i]    = (state_q[i] == ST_OPEN) && (tag_q[i] == wr_tag_i);
            hazard_s[i] = ((state_q[i] == ST_PEND) || (state_q[i] == ST_SENT)) &&
                          (tag_q[i] == wr_tag_i);
            free_s[i]   = (state_q[i] == ST_FREE);
            pend_s[i]   = (state_q[i] == ST_PEND);
            close_s[i]  = (state_q[i] == ST_OPEN) &&
                          (flush_all_i || (timecnt_q[i] >= cfg_threshold_i));
        end
    end

    assign hit_any_s    = |hit_s;
    assign hazard_any_s = |hazard_s;
    assign free_any_s   = |free_s;
    assign pend_any_s   = |pend_s;
    assign hit_id_s     = first_set(hit_s);
    assign free_id_s    = first_set(free_s);
    assign pend_id_s    = first_set(pend_s);

    // A hazard on an in-flight line blocks allocation so writes to it stay ordered
    assign wr_ready_o   = hit_any_s | (~hazard_any_s & free_any_s);
    assign wr_id_o      = hit_any_s ? hit_id_s : free_id_s;
    assign wr_alloc_s   = wr_valid_i & ~hit_any_s & ~hazard_any_s & free_any_s;
    assign send_hs_s    = lock_valid_q & send_ready_i;
    assign ack_sent_s   = (state_q[ack_id_i] == ST_SENT);

    assign empty_o      = &free_s;
    assign full_o       = ~free_any_s;
    assign send_valid_o = lock_valid_q;
    assign send_id_o    = lock_id_q;
    assign send_tag_o   = lock_tag_q;

    // Per-entry next state: allocate, coalesce/age, close, send, free
    always_comb begin
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            state_d[i]   = state_q[i];
            tag_d[i]     = tag_q[i];
            timecnt_d[i] = timecnt_q[i];
            case (state_q[i])
                ST_FREE: begin
                    if (wr_alloc_s && (free_id_s == ID_WIDTH'(i))) begin
                        state_d[i]   = ST_OPEN;
                        tag_d[i]     = wr_tag_i;
                        timecnt_d[i] = '0;
                    end else begin
                        state_d[i]   = ST_FREE;
                    end
                end
                ST_OPEN: begin
                    // Without reset-on-write the timer keeps ageing through coalescing writes
                    if (close_s[i]) begin
                        state_d[i]   = ST_PEND;
                    end else if (wr_valid_i && hit_s[i] && cfg_reset_timecnt_on_write_i) begin
                        timecnt_d[i] = '0;
                    end else if (timecnt_q[i] != '1) begin
                        timecnt_d[i] = timecnt_q[i] + TIMECNT_WIDTH'(1);
                    end else begin
                        timecnt_d[i] = timecnt_q[i];
                    end
                end
                ST_PEND: begin
                    if (send_hs_s && (lock_id_q == ID_WIDTH'(i))) begin
                        state_d[i] = ST_SENT;
                    end else begin
                        state_d[i] = ST_PEND;
                    end
                end
                ST_SENT: begin
                    if (ack_valid_i && (ack_id_i == ID_WIDTH'(i))) begin
                        state_d[i] = ST_FREE;
                    end else begin
                        state_d[i] = ST_SENT;
                    end
                end
                default: begin
                    state_d[i] = ST_FREE;
                end
            endcase
        end
    end

    // Send lock: holds the offered entry stable until the memory handshake
    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        lock_tag_d   = lock_tag_q;
        if (send_hs_s) begin
            lock_valid_d = 1'b0;
        end else if (!lock_valid_q && pend_any_s) begin
            lock_valid_d = 1'b1;
            lock_id_d    = pend_id_s;
            lock_tag_d   = tag_q[pend_id_s];
        end else begin
            lock_valid_d = lock_valid_q;
        end
    end

    // Directory and send-lock registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DIR_ENTRIES; i++) begin
                state_q[i]   <= ST_FREE;
                tag_q[i]     <= '0;
                timecnt_q[i] <= '0;
            end
            lock_valid_q <= 1'b0;
            lock_id_q    <= '0;
            lock_tag_q   <= '0;
        end else begin
            for (int i = 0; i < DIR_ENTRIES; i++) begin
                state_q[i]   <= state_d[i];
                tag_q[i]     <= tag_d[i];
                timecnt_q[i] <= timecnt_d[i];
            end
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            lock_tag_q   <= lock_tag_d;
        end
    end

    // An acknowledgement must only target an entry that was sent
    ack_to_sent_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ack_valid_i |-> ack_sent_s);

endmodule

// File: tb/tb_hpdcache_wbuf_dir_ctrl.sv
// Directed bench for hpdcache_wbuf_dir_ctrl: expected write ids and send offers are queued
// by the stimulus and compared by a monitor whenever the DUT completes a handshake.
module tb_hpdcache_wbuf_dir_ctrl;
    localparam int DIR_ENTRIES   = 8;
    localparam int TAG_WIDTH     = 43;
    localparam int TIMECNT_WIDTH = 5;
    localparam int ID_WIDTH      = 3;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic [TIMECNT_WIDTH-1:0] cfg_threshold_i;
    logic                     cfg_reset_timecnt_on_write_i;
    logic                     wr_valid_i;
    logic                     wr_ready_o;
    logic [TAG_WIDTH-1:0]     wr_tag_i;
    logic [ID_WIDTH-1:0]      wr_id_o;
    logic                     flush_all_i;
    logic                     send_valid_o;
    logic                     send_ready_i;
    logic [TAG_WIDTH-1:0]     send_tag_o;
    logic [ID_WIDTH-1:0]      send_id_o;
    logic                     ack_valid_i;
    logic [ID_WIDTH-1:0]      ack_id_i;
    logic                     empty_o;
    logic                     full_o;

    int n_vec = 0;
    int n_err = 0;
    logic [ID_WIDTH-1:0]          exp_wr_q[$];
    logic [ID_WIDTH+TAG_WIDTH-1:0] exp_send_q[$];

    hpdcache_wbuf_dir_ctrl #(
        .DIR_ENTRIES(DIR_ENTRIES), .TAG_WIDTH(TAG_WIDTH),
        .TIMECNT_WIDTH(TIMECNT_WIDTH), .ID_WIDTH(ID_WIDTH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cfg_threshold_i(cfg_threshold_i),
        .cfg_reset_timecnt_on_write_i(cfg_reset_timecnt_on_write_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_tag_i(wr_tag_i), .wr_id_o(wr_id_o),
        .flush_all_i(flush_all_i),
        .send_valid_o(send_valid_o), .send_ready_i(send_ready_i),
        .send_tag_o(send_tag_o), .send_id_o(send_id_o),
        .ack_valid_i(ack_valid_i), .ack_id_i(ack_id_i),
        .empty_o(empty_o), .full_o(full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [TAG_WIDTH-1:0] tag, input logic [ID_WIDTH-1:0] id);
        wr_valid_i = 1'b1;
        wr_tag_i   = tag;
        exp_wr_q.push_back(id);
        tick();
        wr_valid_i = 1'b0;
    endtask

    task automatic exp_send(input logic [ID_WIDTH-1:0] id, input logic [TAG_WIDTH-1:0] tag);
        exp_send_q.push_back({id, tag});
    endtask

    // Hold send_ready until n handshakes have happened, bounded
    task automatic send_n(input int n);
        int got = 0;
        int cyc = 0;
        send_ready_i = 1'b1;
        while (got < n && cyc < 100) begin
            if (send_valid_o) got++;
            tick();
            cyc++;
        end
        send_ready_i = 1'b0;
        check("send_count", 64'(got), 64'(n));
    endtask

    task automatic ack(input logic [ID_WIDTH-1:0] id);
        ack_valid_i = 1'b1;
        ack_id_i    = id;
        tick();
        ack_valid_i = 1'b0;
    endtask

    task automatic monitor();
        logic [ID_WIDTH+TAG_WIDTH-1:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && wr_valid_i && wr_ready_o) begin
                if (exp_wr_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL wr_unexpected: got id %0d expected no acceptance", wr_id_o);
                end else begin
                    check("wr_id", 64'(wr_id_o), 64'(exp_wr_q.pop_front()));
                end
            end
            if (rst_ni && send_valid_o && send_ready_i) begin
                if (exp_send_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL send_unexpected: got id %0d tag 0x%0h expected none",
                             send_id_o, send_tag_o);
                end else begin
                    e = exp_send_q.pop_front();
                    check("send_id_tag", 64'({send_id_o, send_tag_o}), 64'(e));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0;
        cfg_threshold_i = 5'd3;
        cfg_reset_timecnt_on_write_i = 1'b1;
        wr_valid_i = 1'b0; wr_tag_i = '0; flush_all_i = 1'b0;
        send_ready_i = 1'b0; ack_valid_i = 1'b0; ack_id_i = '0;
        fork
            monitor();
        join_none
        #1;
        check("rst_empty", 64'(empty_o), 64'd1);
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_wr_ready", 64'(wr_ready_o), 64'd1);
        check("rst_send_valid", 64'(send_valid_o), 64'd0);
        check("rst_send_id", 64'(send_id_o), 64'd0);
        check("rst_send_tag", 64'(send_tag_o), 64'd0);
        tick(); tick();
        rst_ni = 1'b1;
        tick();

        // Single write, timer close after 4 idle cycles, offer one cycle later
        wr(43'h10, 3'd0);
        check("t1_not_empty", 64'(empty_o), 64'd0);
        tick(); tick(); tick(); tick();
        check("t1_pend_not_offered", 64'(send_valid_o), 64'd0);
        exp_send(3'd0, 43'h10);
        tick();
        check("t1_send_valid", 64'(send_valid_o), 64'd1);
        check("t1_send_id", 64'(send_id_o), 64'd0);
        check("t1_send_tag", 64'(send_tag_o), 64'h10);
        send_n(1);
        check("t1_lock_cleared", 64'(send_valid_o), 64'd0);
        ack(3'd0);
        check("t1_empty", 64'(empty_o), 64'd1);

        // Coalescing with timer reset on write: stays OPEN through 5 writes
        wr(43'h10, 3'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            wr(43'h10, 3'd0);
        end
        tick(); tick();
        check("t2_open_kept", 64'(send_valid_o), 64'd0);
        tick(); tick();
        check("t2_pend_not_offered", 64'(send_valid_o), 64'd0);
        exp_send(3'd0, 43'h10);
        tick();
        check("t2_send_valid", 64'(send_valid_o), 64'd1);
        send_n(1);
        ack(3'd0);

        // Coalescing without timer reset: closes 4 cycles after allocation, write on close accepted
        cfg_reset_timecnt_on_write_i = 1'b0;
        wr(43'h10, 3'd0);
        tick();
        wr(43'h10, 3'd0);
        tick();
        wr(43'h10, 3'd0);
        check("t3_pend_not_offered", 64'(send_valid_o), 64'd0);
        exp_send(3'd0, 43'h10);
        tick();
        check("t3_send_valid", 64'(send_valid_o), 64'd1);
        check("t3_send_id", 64'(send_id_o), 64'd0);
        send_n(1);
        ack(3'd0);
        check("t3_empty", 64'(empty_o), 64'd1);

        // Fill all entries, 9th write stalls until entry 2 is acked
        cfg_reset_timecnt_on_write_i = 1'b1;
        cfg_threshold_i = 5'd31;
        for (int i = 0; i < 8; i++) wr(TAG_WIDTH'(32'h100 + i), ID_WIDTH'(i));
        check("t4_full", 64'(full_o), 64'd1);
        check("t4_not_empty", 64'(empty_o), 64'd0);
        wr_valid_i = 1'b1;
        wr_tag_i   = 43'h200;
        exp_wr_q.push_back(3'd2);
        #1;
        check("t4_full_stall", 64'(wr_ready_o), 64'd0);
        flush_all_i = 1'b1;
        tick();
        flush_all_i = 1'b0;
        for (int i = 0; i < 3; i++) exp_send(ID_WIDTH'(i), TAG_WIDTH'(32'h100 + i));
        send_n(3);
        check("t4_still_stalled", 64'(wr_ready_o), 64'd0);
        ack(3'd2);
        check("t4_ready_after_ack", 64'(wr_ready_o), 64'd1);
        tick();
        wr_valid_i = 1'b0;
        check("t4_full_again", 64'(full_o), 64'd1);
        ack(3'd0);
        ack(3'd1);
        for (int i = 3; i < 8; i++) exp_send(ID_WIDTH'(i), TAG_WIDTH'(32'h100 + i));
        send_n(5);
        for (int i = 3; i < 8; i++) ack(ID_WIDTH'(i));
        flush_all_i = 1'b1;
        tick();
        flush_all_i = 1'b0;
        exp_send(3'd2, 43'h200);
        send_n(1);
        ack(3'd2);
        check("t4_empty", 64'(empty_o), 64'd1);

        // Hazard: write to a SENT line stalls until its ack, then allocates entry 0
        cfg_threshold_i = 5'd0;
        wr(43'h20, 3'd0);
        exp_send(3'd0, 43'h20);
        send_n(1);
        wr_valid_i = 1'b1;
        wr_tag_i   = 43'h20;
        exp_wr_q.push_back(3'd0);
        #1;
        check("t5_hazard_stall", 64'(wr_ready_o), 64'd0);
        tick(); tick();
        check("t5_hazard_held", 64'(wr_ready_o), 64'd0);
        ack(3'd0);
        check("t5_ready_after_ack", 64'(wr_ready_o), 64'd1);
        tick();
        wr_valid_i = 1'b0;
        exp_send(3'd0, 43'h20);
        send_n(1);
        ack(3'd0);

        // Send lock: entry 3 stays offered while lower entry 1 becomes PEND
        cfg_threshold_i = 5'd31;
        for (int i = 0; i < 4; i++) wr(TAG_WIDTH'(32'h50 + i), ID_WIDTH'(i));
        flush_all_i = 1'b1;
        tick();
        flush_all_i = 1'b0;
        for (int i = 0; i < 3; i++) exp_send(ID_WIDTH'(i), TAG_WIDTH'(32'h50 + i));
        send_n(3);
        ack(3'd1);
        ack(3'd2);
        tick();
        check("t6_lock_valid", 64'(send_valid_o), 64'd1);
        check("t6_lock_id", 64'(send_id_o), 64'd3);
        check("t6_lock_tag", 64'(send_tag_o), 64'h53);
        wr(43'h41, 3'd1);
        flush_all_i = 1'b1;
        tick();
        flush_all_i = 1'b0;
        tick(); tick();
        check("t6_lock_held_id", 64'(send_id_o), 64'd3);
        exp_send(3'd3, 43'h53);
        exp_send(3'd1, 43'h41);
        send_n(2);
        ack(3'd0);
        ack(3'd3);
        ack(3'd1);
        check("t6_empty", 64'(empty_o), 64'd1);

        // Mid-operation reset with 2 SENT and 4 OPEN entries
        wr(43'h60, 3'd0);
        wr(43'h61, 3'd1);
        flush_all_i = 1'b1;
        tick();
        flush_all_i = 1'b0;
        exp_send(3'd0, 43'h60);
        exp_send(3'd1, 43'h61);
        send_n(2);
        for (int i = 2; i < 6; i++) wr(TAG_WIDTH'(32'h60 + i), ID_WIDTH'(i));
        check("t7_not_empty", 64'(empty_o), 64'd0);
        rst_ni = 1'b0;
        #1;
        check("t7_rst_empty", 64'(empty_o), 64'd1);
        check("t7_rst_send_valid", 64'(send_valid_o), 64'd0);
        tick(); tick();
        rst_ni = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t7_no_spurious_send", 64'(send_valid_o), 64'd0);
        end
        check("t7_empty_after", 64'(empty_o), 64'd1);

        check("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
        check("send_queue_drained", 64'(exp_send_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
